// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime-configurable framing (5..9 data bits,
// parity, one or two stop bits), break detection and a small status FIFO.
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic [3:0] data_bits,
    input  logic [1:0] parity_mode,
    input  logic       two_stop,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       break_det,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic       rx_busy,
    output logic [2:0] state_dbg
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE/2 - 1);
    localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE/2);
    localparam logic [PW-1:0] PH_S2  = PW'(OVERSAMPLE/2 + 1);
    localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP1   = 3'd4,
        STOP2   = 3'd5,
        BRKWAIT = 3'd6
    } state_t;

    state_t        state;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [PW-1:0] phase;
    logic          s0, s1;
    logic          maj;
    logic [3:0]    bit_cnt;
    logic [3:0]    nbits_q;
    logic [3:0]    nbits_in;
    logic          par_en_q, par_odd_q, two_stop_q;
    logic [8:0]    data_q;
    logic          par_bit_q, pe_q, fe_q;
    logic          brk;
    logic          push;
    logic [11:0]   push_word;
    logic          at_s0, at_s1, at_dec, at_end;

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

    assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign at_s0    = (phase == PH_S0);
    assign at_s1    = (phase == PH_S1);
    assign at_dec   = (phase == PH_S2);
    assign at_end   = (phase == PH_END);
    assign nbits_in = (data_bits < 4'd5) ? 4'd5 : (data_bits > 4'd9) ? 4'd9 : data_bits;
    assign brk      = (data_q == '0) && !(par_en_q && par_bit_q) && !maj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            bit_cnt    <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            push       <= 1'b0;
            push_word  <= '0;
        end else begin
            push <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            // Framing config is captured here and held for the whole character.
                            state      <= START;
                            phase      <= '0;
                            nbits_q    <= nbits_in;
                            par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                            par_odd_q  <= (parity_mode == 2'b10);
                            two_stop_q <= two_stop;
                            data_q     <= '0;
                            bit_cnt    <= '0;
                            par_bit_q  <= 1'b0;
                            pe_q       <= 1'b0;
                            fe_q       <= 1'b0;
                        end
                    end
                    BRKWAIT: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: begin
                        phase <= at_end ? '0 : phase + 1'b1;
                        if (at_s0) s0 <= rx_s;
                        if (at_s1) s1 <= rx_s;
                        case (state)
                            START: begin
                                if (at_dec && maj) begin
                                    state <= IDLE;
                                    phase <= '0;
                                end else if (at_end) begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                if (at_dec) data_q[bit_cnt] <= maj;
                                if (at_end) begin
                                    if (bit_cnt == nbits_q - 4'd1)
                                        state <= par_en_q ? PARITY : STOP1;
                                    else
                                        bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                            PARITY: begin
                                if (at_dec) begin
                                    par_bit_q <= maj;
                                    pe_q      <= (^data_q) ^ maj ^ par_odd_q;
                                end
                                if (at_end) state <= STOP1;
                            end
                            STOP1: begin
                                if (at_dec) begin
                                    if (brk) begin
                                        push      <= 1'b1;
                                        push_word <= {1'b1, 1'b1, pe_q, data_q};
                                        state     <= BRKWAIT;
                                        phase     <= '0;
                                    end else if (!two_stop_q) begin
                                        push      <= 1'b1;
                                        push_word <= {1'b0, ~maj, pe_q, data_q};
                                        state     <= IDLE;
                                        phase     <= '0;
                                    end else begin
                                        fe_q <= ~maj;
                                    end
                                end else if (at_end) begin
                                    state <= STOP2;
                                end
                            end
                            STOP2: begin
                                if (at_dec) begin
                                    push      <= 1'b1;
                                    push_word <= {1'b0, fe_q | ~maj, pe_q, data_q};
                                    state     <= IDLE;
                                    phase     <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign rx_busy   = (state != IDLE);
    assign state_dbg = state;

    // FIFO: extra pointer bit separates full from empty; a pop frees its slot
    // in the same cycle so a simultaneous push into a full FIFO still lands.
    logic [11:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, pop, wr_en;
    logic [11:0] head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && rx_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= push_word;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            else if (clear_overflow)  overflow <= 1'b0;
        end
    end

    assign head        = mem[rptr[AW-1:0]];
    assign rx_valid    = !empty;
    assign rx_data     = rx_valid ? head[8:0] : '0;
    assign parity_err  = rx_valid & head[9];
    assign framing_err = rx_valid & head[10];
    assign break_det   = rx_valid & head[11];

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: serial driver, expected-word queue
// checked against every FIFO pop, plus directed reset/glitch/break/overflow cases.
module tb_uart_rx_param;

    localparam int OS       = 16;
    localparam int TICK_DIV = 2;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk;
    logic       reset_n;
    logic       baud_tick;
    logic       rx;
    logic [3:0] data_bits;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err, framing_err, break_det;
    logic       overflow;
    logic       clear_overflow;
    logic       rx_busy;
    logic [2:0] state_dbg;

    logic [11:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_param #(.OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .baud_tick      (baud_tick),
        .rx             (rx),
        .data_bits      (data_bits),
        .parity_mode    (parity_mode),
        .two_stop       (two_stop),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .parity_err     (parity_err),
        .framing_err    (framing_err),
        .break_det      (break_det),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .rx_busy        (rx_busy),
        .state_dbg      (state_dbg)
    );

    // Clock, baud tick (one clk pulse every TICK_DIV clks) and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 baud_tick = ~baud_tick;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted pop is compared against the oldest expected word
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("rx_word", {20'd0, break_det, framing_err, parity_err, rx_data},
                         {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        #1 rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_char(input logic [8:0] d, input int nb, input logic [1:0] pm,
                             input logic ts, input logic flip_par, input logic st2,
                             input logic expect_push);
        int          nbc;
        logic [8:0]  mask;
        logic [8:0]  dm;
        logic        pen, pbit, fe;
        nbc  = (nb < 5) ? 5 : (nb > 9) ? 9 : nb;
        mask = 9'h1FF >> (9 - nbc);
        dm   = d & mask;
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pbit = (^dm) ^ (pm == 2'b10) ^ flip_par;
        fe   = ts & ~st2;
        data_bits   = 4'(nb);
        parity_mode = pm;
        two_stop    = ts;
        if (expect_push) exp_q.push_back({1'b0, fe, pen & flip_par, dm});
        send_bit(1'b0);
        for (int i = 0; i < nbc; i++) send_bit(dm[i]);
        if (pen) send_bit(pbit);
        send_bit(1'b1);
        if (ts) send_bit(st2);
        send_bit(1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [8:0] d;
        rx             = 1'b1;
        reset_n        = 1'b0;
        rx_ready       = 1'b1;
        clear_overflow = 1'b0;
        data_bits      = 4'd8;
        parity_mode    = 2'b00;
        two_stop       = 1'b0;

        // Reset state
        wait_clks(5);
        check_eq("rst_valid",    32'(rx_valid), 32'd0);
        check_eq("rst_data",     32'(rx_data), 32'd0);
        check_eq("rst_status",   32'({break_det, framing_err, parity_err}), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy",     32'(rx_busy), 32'd0);
        check_eq("rst_state",    32'(state_dbg), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_clks(BIT_CLKS);
        check_eq("post_rst_busy", 32'(rx_busy), 32'd0);

        // 8N1 0xA5
        send_char(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_a5");
        check_eq("a5_single_push", 32'(rx_valid), 32'd0);

        // 9 data bits, odd parity, wrong parity bit
        send_char(9'h1FF, 9, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain("drain_1ff");

        // Random framings, including out-of-range data_bits
        for (int i = 0; i < 6; i++) begin
            send_char(9'($urandom_range(0, 511)), $urandom_range(3, 11),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        wait_drain("drain_rand");

        // Two-sample low glitch: false start, nothing pushed
        data_bits   = 4'd8;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        wait_clks(2);
        check_eq("glitch_busy", 32'(rx_busy), 32'd1);
        wait_clks(24);
        check_eq("glitch_idle",  32'(rx_busy), 32'd0);
        check_eq("glitch_valid", 32'(rx_valid), 32'd0);

        // Break in 8E1: rx low for 20 bit times
        data_bits   = 4'd8;
        parity_mode = 2'b01;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 9'h000});
        repeat (15) send_bit(1'b0);
        check_eq("brk_busy", 32'(rx_busy), 32'd1);
        check_eq("brk_q",    32'(exp_q.size()), 32'd0);
        repeat (5) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #1;
        check_eq("brk_idle",  32'(rx_busy), 32'd0);
        check_eq("brk_valid", 32'(rx_valid), 32'd0);

        // Overflow: 5 characters into a 4-deep FIFO with no reads
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 9'($urandom_range(0, 255));
            send_char(d, 8, 2'b00, 1'b0, 1'b0, 1'b1, (i < 4));
        end
        check_eq("ovf_set",   32'(overflow), 32'd1);
        check_eq("ovf_valid", 32'(rx_valid), 32'd1);
        check_eq("ovf_q",     32'(exp_q.size()), 32'd4);
        #1 rx_ready = 1'b1;
        wait_drain("drain_ovf");
        wait_clks(2);
        check_eq("ovf_empty",  32'(rx_valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        wait_clks(1);
        clear_overflow = 1'b0;
        check_eq("ovf_clear", 32'(overflow), 32'd0);

        // Two stop bits, second one low
        send_char(9'h03C, 8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_drain("drain_stop2");

        // Reset mid-DATA with a word waiting in the FIFO
        rx_ready = 1'b0;
        send_char(9'h011, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pre_rst_valid", 32'(rx_valid), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #1;
        check_eq("mid_busy", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        rx      = 1'b1;
        #2;
        check_eq("mid_rst_valid", 32'(rx_valid), 32'd0);
        check_eq("mid_rst_busy",  32'(rx_busy), 32'd0);
        wait_clks(3);
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check_eq("post_mid_valid", 32'(rx_valid), 32'd0);
        send_char(9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_after_rst");
        wait_clks(BIT_CLKS);
        check_eq("final_valid", 32'(rx_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
